// File: rtl/reg_file_pkg.sv
// Shared sizes, types and the write-select legality check for the
// eight-entry register file.
package reg_file_pkg;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;

    typedef logic [NUM_REGS-1:0] wr_sel_t;
    typedef logic [ADDR_W-1:0]   reg_addr_t;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    function automatic logic is_onehot(input wr_sel_t sel);
        return (sel != '0) && ((sel & (sel - wr_sel_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/reg_file_8x_if.sv
// Write-select / read-port bundle between the decoder-side logic and the
// register file; clock and reset stay outside the bundle.
interface reg_file_8x_if #(
    parameter int WIDTH = 8
);
    import reg_file_pkg::*;

    wr_sel_t            wr_sel;
    logic [WIDTH-1:0]   wr_data;
    reg_addr_t          rd_addr_a;
    reg_addr_t          rd_addr_b;
    logic               rd_en_a;
    logic               rd_en_b;
    logic               err_clr;
    logic [WIDTH-1:0]   rd_data_a;
    logic [WIDTH-1:0]   rd_data_b;
    logic               rd_valid_a;
    logic               rd_valid_b;
    wr_sel_t            valid_map;
    logic               err_onehot;

    modport master (
        output wr_sel, wr_data, rd_addr_a, rd_addr_b, rd_en_a, rd_en_b, err_clr,
        input  rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, valid_map, err_onehot
    );

    modport slave (
        input  wr_sel, wr_data, rd_addr_a, rd_addr_b, rd_en_a, rd_en_b, err_clr,
        output rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, valid_map, err_onehot
    );

endinterface

// File: rtl/rf_read_port.sv
// One registered read port: address mux, write-through bypass and an
// enabled output register.
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             rd_en,
    input  reg_addr_t                        rd_addr,
    input  logic [NUM_REGS-1:0][WIDTH-1:0]   regs,
    input  wr_sel_t                          valid_map,
    input  wr_sel_t                          wr_commit,
    input  logic [WIDTH-1:0]                 wr_data,
    output logic [WIDTH-1:0]                 rd_data,
    output logic                             rd_valid
);

    logic [WIDTH-1:0] next_data;
    logic             next_valid;

    // wr_commit already excludes illegal and discarded writes, so they never bypass.
    always_comb begin
        next_data  = regs[rd_addr];
        next_valid = valid_map[rd_addr];
        if (wr_commit[rd_addr]) begin
            next_data  = wr_data;
            next_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_data  <= next_data;
            rd_valid <= next_valid;
        end
    end

endmodule

// File: rtl/reg_file_8x.sv
// Eight-entry register file written by a one-hot select, with two bypassed
// read ports, a per-entry valid scoreboard and a sticky illegal-select flag.
module reg_file_8x
    import reg_file_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit ZERO_REG0 = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_file_8x_if.slave    bus
);

    localparam wr_sel_t VALID_RESET = wr_sel_t'(ZERO_REG0);

    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    wr_sel_t                        valid_map;
    wr_sel_t                        wr_commit;
    logic                           wr_legal;
    logic                           wr_illegal;
    logic                           err_onehot;
    logic [WIDTH-1:0]               rd_data_a;
    logic [WIDTH-1:0]               rd_data_b;
    logic                           rd_valid_a;
    logic                           rd_valid_b;

    // wr_commit is the set of entries actually updated this edge.
    always_comb begin
        wr_legal   = is_onehot(bus.wr_sel);
        wr_illegal = (bus.wr_sel != '0) && !wr_legal;
        wr_commit  = wr_legal ? bus.wr_sel : '0;
        if (ZERO_REG0) begin
            wr_commit[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_commit[i]) begin
                    regs[i] <= bus.wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_map <= VALID_RESET;
        end else begin
            valid_map <= valid_map | wr_commit;
        end
    end

    // Setting on an illegal select takes priority over a same-edge clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_onehot <= 1'b0;
        end else if (wr_illegal) begin
            err_onehot <= 1'b1;
        end else if (bus.err_clr) begin
            err_onehot <= 1'b0;
        end
    end

    rf_read_port #(.WIDTH(WIDTH)) u_port_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (bus.rd_en_a),
        .rd_addr   (bus.rd_addr_a),
        .regs      (regs),
        .valid_map (valid_map),
        .wr_commit (wr_commit),
        .wr_data   (bus.wr_data),
        .rd_data   (rd_data_a),
        .rd_valid  (rd_valid_a)
    );

    rf_read_port #(.WIDTH(WIDTH)) u_port_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (bus.rd_en_b),
        .rd_addr   (bus.rd_addr_b),
        .regs      (regs),
        .valid_map (valid_map),
        .wr_commit (wr_commit),
        .wr_data   (bus.wr_data),
        .rd_data   (rd_data_b),
        .rd_valid  (rd_valid_b)
    );

    assign bus.rd_data_a  = rd_data_a;
    assign bus.rd_data_b  = rd_data_b;
    assign bus.rd_valid_a = rd_valid_a;
    assign bus.rd_valid_b = rd_valid_b;
    assign bus.valid_map  = valid_map;
    assign bus.err_onehot = err_onehot;

endmodule

// File: doc/reg_file_8x.md
Name: reg_file_8x

Overview:
- Eight-entry register file that sits directly downstream of the 3-to-8 write-select decoder.
- It consumes the decoder's one-hot 8-bit enable vector as its write select.
- Two registered read ports with write-through bypass.
- Per-entry valid scoreboard.
- Sticky error flag for illegal (non-one-hot) write selects.

Parameters:
- WIDTH, 8, data width of each register.
- ZERO_REG0, 0, when 1 register 0 reads as zero, ignores writes and is always valid.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- wr_sel  input  8  one-hot write select from the decoder; all-zero means no write
- wr_data  input  WIDTH  write data
- rd_addr_a  input  3  read port A address
- rd_addr_b  input  3  read port B address
- rd_en_a  input  1  read port A enable
- rd_en_b  input  1  read port B enable
- rd_data_a  output  WIDTH  read port A data (registered)
- rd_data_b  output  WIDTH  read port B data (registered)
- rd_valid_a  output  1  entry addressed on port A had been written since reset
- rd_valid_b  output  1  entry addressed on port B had been written since reset
- valid_map  output  8  per-entry written flags
- err_onehot  output  1  sticky: a write select with more than one bit set was seen
- err_clr  input  1  synchronous clear of err_onehot

Behaviour:
- Reset: one clock; reset is asynchronous and active-low on rst_n. While rst_n=0 (asserted asynchronously):
  - all registers = 0
  - valid_map = 0, or 8'h01 if ZERO_REG0=1
  - rd_data_a/b = 0, rd_valid_a/b = 0, err_onehot = 0
- Write legality, checked at each rising edge:
  - wr_sel with exactly one bit set is legal.
  - All-zero wr_sel is an idle cycle.
  - Two or more bits set is illegal: no register is written, and err_onehot sets to 1 on that edge.
- Legal write: the selected register takes wr_data and its valid_map bit sets to 1 on the same edge.
- ZERO_REG0=1 and wr_sel=8'h01: the write is discarded, is not an error, and valid_map[0] stays 1.
- Reads:
  - Latency is 1 cycle. rd_en_x=1 at edge N makes rd_data_x/rd_valid_x reflect rd_addr_x from edge N onward.
  - rd_en_x=0 holds the previous rd_data_x/rd_valid_x.
- Write-through bypass: if edge N carries a legal write to the register addressed by an enabled read, that read returns wr_data and rd_valid=1, not the old contents.
  - An illegal write is never bypassed.
  - A discarded write to register 0 under ZERO_REG0=1 is never bypassed.
- Unwritten entries: reads return stored contents (0 after reset) with rd_valid=0.
- Ports A and B are independent. Both may address the same entry in the same cycle.
- err_onehot:
  - err_clr=1 clears it at the next edge.
  - If err_clr=1 and an illegal write occur on the same edge, set wins and err_onehot stays 1.
- valid_map bits only return to 0 through reset. There is no per-entry invalidate.
- Reset asserted mid-operation aborts any write on that cycle. The first edge after rst_n rises behaves as a normal cycle.
- State: 8xWIDTH data flops, 8 valid flops, 2x(WIDTH+1) read-output flops, 1 error flop.

Decomposition:
- Package reg_file_pkg:
  - NUM_REGS=8, ADDR_W=3
  - typedef logic [NUM_REGS-1:0] wr_sel_t
  - typedef logic [ADDR_W-1:0] reg_addr_t
  - function is_onehot(wr_sel_t) returning legality
- Sub-module rf_read_port: one instance per port. It contains the address mux, the bypass compare and the output register with enable. Instanced twice.
- The upstream decoder is not instantiated inside this block.

Test Plan:
- Reset with wr_sel=8'h10, wr_data=8'hA5 held; release rst_n -> first edge writes reg4; valid_map=8'h10; read A of addr 4 next cycle gives 8'hA5, rd_valid_a=1.
- Same edge: wr_sel=8'h08, wr_data=8'h3C, rd_en_a=1, rd_addr_a=3 -> rd_data_a=8'h3C, rd_valid_a=1 after that edge (bypass). Port B reading addr 3 with rd_en_b=0 holds its prior value.
- wr_sel=8'h81, wr_data=8'hFF -> reg0 and reg7 unchanged, valid_map unchanged, err_onehot=1. Then err_clr=1 alone -> err_onehot=0. Then err_clr=1 together with wr_sel=8'h06 -> err_onehot stays 1.
- ZERO_REG0=1: wr_sel=8'h01, wr_data=8'h55, read A addr 0 same edge -> rd_data_a=0, rd_valid_a=1, err_onehot=0.
- Read unwritten addr 6 after reset -> rd_data=0, rd_valid=0. Write all 8 entries with values 8'h10+i, then read them all on both ports -> correct data and valid_map=8'hFF.
- Assert rst_n low asynchronously mid-cycle during a legal write to reg2 -> outputs go 0 immediately, valid_map returns to its reset value, and reg2 reads 0 after release.
